// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared, purely combinational ALU.
//
// Each requester hands over an operation (aluop, s, t, shamt) with a valid/ready
// handshake. The arbiter registers the granted operation onto alu_*, waits one
// cycle for the ALU to settle, captures alu_out/zero/overflow into the grantee's
// response registers, and holds them until the grantee takes them. Only one
// operation is ever in flight.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   reqK_valid / reqK_ready        request handshake, K = 0, 1
//   reqK_aluop, reqK_s, reqK_t,    operation and operands of requester K
//   reqK_shamt
//   respK_valid / respK_ready      response handshake, K = 0, 1
//   respK_out, respK_zero,         captured ALU result and flags for requester K
//   respK_overflow
//   alu_aluop, alu_s, alu_t,       registered operation driving the shared ALU
//   alu_shamt
//   alu_out, alu_zero,             combinational results from the shared ALU
//   alu_overflow
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins contention.
//                          undefined: round-robin between the two requesters.
module alu_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [4:0]   req0_aluop,
  input  logic [N-1:0] req0_s,
  input  logic [N-1:0] req0_t,
  input  logic [4:0]   req0_shamt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [4:0]   req1_aluop,
  input  logic [N-1:0] req1_s,
  input  logic [N-1:0] req1_t,
  input  logic [4:0]   req1_shamt,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [N-1:0] resp0_out,
  output logic         resp0_zero,
  output logic         resp0_overflow,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp1_out,
  output logic         resp1_zero,
  output logic         resp1_overflow,
  output logic [4:0]   alu_aluop,
  output logic [N-1:0] alu_s,
  output logic [N-1:0] alu_t,
  output logic [4:0]   alu_shamt,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_overflow
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q;
  logic   grantee_q;   // 0: requester 0 owns the in-flight operation, 1: requester 1
  logic   grant0, grant1;
  logic   resp_taken;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   last_grant_q;
`endif

  // Grant decision is combinational so ready can rise in the same cycle as valid.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant0 = req0_valid;
`else
    // Under contention, requester 0 wins only if requester 1 was granted last.
    grant0 = req0_valid && (!req1_valid || last_grant_q);
`endif
    grant1     = req1_valid && !grant0;
    req0_ready = (state_q == StIdle) && grant0;
    req1_ready = (state_q == StIdle) && grant1;
    resp_taken = grantee_q ? resp1_ready : resp0_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      grantee_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q   <= 1'b1;
`endif
      alu_aluop      <= '0;
      alu_s          <= '0;
      alu_t          <= '0;
      alu_shamt      <= '0;
      resp0_valid    <= 1'b0;
      resp0_out      <= '0;
      resp0_zero     <= 1'b0;
      resp0_overflow <= 1'b0;
      resp1_valid    <= 1'b0;
      resp1_out      <= '0;
      resp1_zero     <= 1'b0;
      resp1_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            alu_aluop    <= grant0 ? req0_aluop : req1_aluop;
            alu_s        <= grant0 ? req0_s     : req1_s;
            alu_t        <= grant0 ? req0_t     : req1_t;
            alu_shamt    <= grant0 ? req0_shamt : req1_shamt;
            grantee_q    <= grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= grant1;
`endif
            state_q      <= StExec;
          end
        end
        // alu_* has been stable for a full cycle; the accept edge counts as the
        // first of the two edges before the response is visible.
        StExec: begin
          if (grantee_q) begin
            resp1_out      <= alu_out;
            resp1_zero     <= alu_zero;
            resp1_overflow <= alu_overflow;
            resp1_valid    <= 1'b1;
          end else begin
            resp0_out      <= alu_out;
            resp0_zero     <= alu_zero;
            resp0_overflow <= alu_overflow;
            resp0_valid    <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (resp_taken) begin
            if (grantee_q) resp1_valid <= 1'b0;
            else           resp0_valid <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU attached to alu_*.
module tb_alu_arbiter;
  localparam int N = 32;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2;
  localparam logic [4:0] OP_BEQ = 5'd3, OP_AND = 5'd4, OP_OR  = 5'd5;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]   req0_aluop, req1_aluop, req0_shamt, req1_shamt;
  logic [N-1:0] req0_s, req0_t, req1_s, req1_t;
  logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [N-1:0] resp0_out, resp1_out;
  logic         resp0_zero, resp0_overflow, resp1_zero, resp1_overflow;
  logic [4:0]   alu_aluop, alu_shamt;
  logic [N-1:0] alu_s, alu_t, alu_out;
  logic         alu_zero, alu_overflow;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_s(req0_s), .req0_t(req0_t), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_s(req1_s), .req1_t(req1_t), .req1_shamt(req1_shamt),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_out(resp0_out),
    .resp0_zero(resp0_zero), .resp0_overflow(resp0_overflow),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_out(resp1_out),
    .resp1_zero(resp1_zero), .resp1_overflow(resp1_overflow),
    .alu_aluop(alu_aluop), .alu_s(alu_s), .alu_t(alu_t), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, zero, out}.
  function automatic logic [N+1:0] alu_ref(input logic [4:0] op, input logic [N-1:0] s,
                                           input logic [N-1:0] t, input logic [4:0] sh);
    logic [N-1:0] r;
    logic ov;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        r  = s + t;
        ov = (s[N-1] == t[N-1]) && (r[N-1] != s[N-1]);
      end
      OP_SUB: begin
        r  = s - t;
        ov = (s[N-1] != t[N-1]) && (r[N-1] != s[N-1]);
      end
      OP_BEQ:  r = s - t;
      OP_SLL:  r = s << sh;
      OP_AND:  r = s & t;
      OP_OR:   r = s | t;
      default: r = '0;
    endcase
    return {ov, (r == '0), r};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_out} = alu_ref(alu_aluop, alu_s, alu_t, alu_shamt);

  task automatic clear_inputs();
    req0_valid = 0; req0_aluop = 0; req0_s = 0; req0_t = 0; req0_shamt = 0;
    req1_valid = 0; req1_aluop = 0; req1_s = 0; req1_t = 0; req1_shamt = 0;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  // Leaves the bench at a negedge with rst_n high and no post-reset edge yet.
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {resp0_valid, resp1_valid, req0_ready, req1_ready});
    end
    checks++;
    if ({resp0_out, resp0_zero, resp0_overflow, resp1_out, resp1_zero, resp1_overflow} !== '0) begin
      failures++;
      $display("FAIL reset_resp: got %h %h expected 0 0", resp0_out, resp1_out);
    end
    checks++;
    if ({alu_aluop, alu_s, alu_t, alu_shamt} !== '0) begin
      failures++;
      $display("FAIL reset_alu: got op=%h s=%h t=%h sh=%h expected all 0",
               alu_aluop, alu_s, alu_t, alu_shamt);
    end
    rst_n = 1;
  endtask

  task automatic test_single_add();
    do_reset();
    req0_valid = 1; req0_aluop = OP_ADD; req0_s = 5; req0_t = 7;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; #1;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL add_exec_flags: got %b expected 0000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
    checks++;
    if ({alu_aluop, alu_s, alu_t} !== {OP_ADD, 32'd5, 32'd7}) begin
      failures++;
      $display("FAIL add_alu_operands: got op=%h s=%h t=%h expected 0 5 7", alu_aluop, alu_s, alu_t);
    end
    @(negedge clk); #1;
    checks++;
    if ({resp0_valid, resp1_valid, req1_ready} !== 3'b100) begin
      failures++;
      $display("FAIL add_resp_flags: got %b expected 100", {resp0_valid, resp1_valid, req1_ready});
    end
    checks++;
    if ({resp0_out, resp0_zero, resp0_overflow} !== {32'd12, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_result: got %h z=%b o=%b expected 0000000c z=0 o=0",
               resp0_out, resp0_zero, resp0_overflow);
    end
    req1_valid = 0; resp0_ready = 1;
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0) begin
      failures++; $display("FAIL add_release: got valid=%b expected 0", resp0_valid);
    end
    resp0_ready = 0;
  endtask

  task automatic test_overflow_req1();
    do_reset();
    req1_valid = 1; req1_aluop = OP_ADD; req1_s = 32'h7FFF_FFFF; req1_t = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL ovf_ready: got %b expected 01", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    checks++;
    if ({resp1_valid, resp1_out, resp1_zero, resp1_overflow} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ovf_result: got v=%b %h z=%b o=%b expected v=1 80000000 z=0 o=1",
               resp1_valid, resp1_out, resp1_zero, resp1_overflow);
    end
    checks++;
    if ({resp0_valid, resp0_out, resp0_zero, resp0_overflow} !== '0) begin
      failures++;
      $display("FAIL ovf_other_side: got v=%b %h expected v=0 00000000", resp0_valid, resp0_out);
    end
    resp1_ready = 1;
    @(negedge clk);
    checks++;
    if (resp1_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_release: got valid=%b expected 0", resp1_valid);
    end
    resp1_ready = 0;
  endtask

  task automatic test_beq_hold();
    do_reset();
    req0_valid = 1; req0_aluop = OP_BEQ; req0_s = 9; req0_t = 9;
    @(negedge clk);
    req0_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_valid = 1; req1_valid = 1; #1;
      checks++;
      if ({resp0_valid, resp0_zero, resp0_out, req0_ready, req1_ready, resp1_valid} !==
          {1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL beq_hold[%0d]: got v=%b z=%b out=%h rdy=%b%b v1=%b expected v=1 z=1 out=0 rdy=00 v1=0",
                 i, resp0_valid, resp0_zero, resp0_out, req0_ready, req1_ready, resp1_valid);
      end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; resp0_ready = 1;
    @(negedge clk);
    resp0_ready = 0;
    checks++;
    if (resp0_valid !== 1'b0) begin
      failures++; $display("FAIL beq_release: got valid=%b expected 0", resp0_valid);
    end
    req0_valid = 1; #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL beq_back_idle: got ready=%b expected 1", req0_ready);
    end
    req0_valid = 0;
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    req0_valid = 1; req0_aluop = OP_ADD; req0_s = 1; req0_t = 2;
    @(negedge clk);
    req0_valid = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    checks++;
    if ({alu_aluop, alu_s, alu_t, alu_shamt} !== '0) begin
      failures++;
      $display("FAIL rexec_alu: got op=%h s=%h t=%h expected all 0", alu_aluop, alu_s, alu_t);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({resp0_valid, resp1_valid, resp0_out, resp1_out} !== '0) begin
        failures++;
        $display("FAIL rexec_no_resp[%0d]: got v=%b%b out=%h %h expected v=00 out=0 0",
                 i, resp0_valid, resp1_valid, resp0_out, resp1_out);
      end
      @(negedge clk);
    end
    req0_valid = 1; req1_valid = 1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rexec_idle_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, seen0, seen1;
    acc0 = -1; acc1 = -1; seen0 = -1; seen1 = -1;
    do_reset();
    resp0_ready = 1; resp1_ready = 1;
    req0_valid = 1; req0_aluop = OP_SLL; req0_s = 1; req0_t = 0; req0_shamt = 4;
    req1_valid = 1; req1_aluop = OP_SUB; req1_s = 3; req1_t = 10;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (acc0 >= 0) req0_valid = 0;
      if (acc1 >= 0) req1_valid = 0;
      #1;
      if (resp0_valid && seen0 < 0) begin
        seen0 = i;
        checks++;
        if (resp0_out !== 32'd16) begin
          failures++; $display("FAIL b2b_sll: got %h expected 00000010", resp0_out);
        end
      end
      if (resp1_valid && seen1 < 0) begin
        seen1 = i;
        checks++;
        if (resp1_out !== 32'hFFFF_FFF9) begin
          failures++; $display("FAIL b2b_sub: got %h expected fffffff9", resp1_out);
        end
      end
      if (req0_valid && req0_ready) acc0 = i;
      if (req1_valid && req1_ready) acc1 = i;
    end
    checks++;
    if (acc0 !== 0 || acc1 !== 3) begin
      failures++;
      $display("FAIL b2b_issue: got accepts at %0d,%0d expected 0,3 (interval 3)", acc0, acc1);
    end
    checks++;
    if (seen0 !== 2 || seen1 !== 5) begin
      failures++;
      $display("FAIL b2b_latency: got responses at %0d,%0d expected 2,5", seen0, seen1);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int grants[$];
    int last, expw, both;
    both = 0;
    do_reset();
    resp0_ready = 1; resp1_ready = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (req0_ready && req1_ready) both++;
      else if (req0_ready) grants.push_back(0);
      else if (req1_ready) grants.push_back(1);
    end
    checks++;
    if (both != 0 || grants.size() < 4) begin
      failures++;
      $display("FAIL rr_count: got %0d grants, %0d double grants expected >=4 and 0",
               grants.size(), both);
    end
    last = 1;
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      expw = FIXED ? 0 : 1 - last;
      last = expw;
      checks++;
      if (grants[i] != expw) begin
        failures++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, grants[i], expw);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int last, winner, k;
    bit busy, vis;
    logic [N-1:0] eo0, eo1, is_, it;
    logic ez0, ez1, eov0, eov1;
    logic [4:0] iop, ish;
    logic [N+1:0] r;
    do_reset();
    last = 1; busy = 0; vis = 0; k = 0;
    eo0 = 0; eo1 = 0; ez0 = 0; ez1 = 0; eov0 = 0; eov1 = 0;
    iop = 0; ish = 0; is_ = 0; it = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp1_valid} !== {vis && k == 0, vis && k == 1}) begin
        failures++;
        $display("FAIL rnd_valid[%0d]: got %b%b expected %b%b", c, resp0_valid, resp1_valid,
                 vis && k == 0, vis && k == 1);
      end
      checks++;
      if ({resp0_out, resp0_zero, resp0_overflow, resp1_out, resp1_zero, resp1_overflow} !==
          {eo0, ez0, eov0, eo1, ez1, eov1}) begin
        failures++;
        $display("FAIL rnd_resp[%0d]: got %h/%b%b %h/%b%b expected %h/%b%b %h/%b%b", c,
                 resp0_out, resp0_zero, resp0_overflow, resp1_out, resp1_zero, resp1_overflow,
                 eo0, ez0, eov0, eo1, ez1, eov1);
      end
      checks++;
      if ({alu_aluop, alu_s, alu_t, alu_shamt} !== {iop, is_, it, ish}) begin
        failures++;
        $display("FAIL rnd_alu[%0d]: got %h %h %h %h expected %h %h %h %h", c,
                 alu_aluop, alu_s, alu_t, alu_shamt, iop, is_, it, ish);
      end
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_aluop = 5'($urandom_range(0, 5)); req1_aluop = 5'($urandom_range(0, 5));
      req0_s = $urandom; req1_s = $urandom;
      req0_t = ($urandom_range(0, 3) == 0) ? req0_s : $urandom;
      req1_t = ($urandom_range(0, 3) == 0) ? req1_s : $urandom;
      req0_shamt = 5'($urandom_range(0, 31)); req1_shamt = 5'($urandom_range(0, 31));
      resp0_ready = 1'($urandom_range(0, 1)); resp1_ready = 1'($urandom_range(0, 1));
      #1;
      winner = -1;
      if (!busy) begin
        if (req0_valid && req1_valid) winner = FIXED ? 0 : 1 - last;
        else if (req0_valid)          winner = 0;
        else if (req1_valid)          winner = 1;
      end
      checks++;
      if ({req0_ready, req1_ready} !== {winner == 0, winner == 1}) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", c, req0_ready, req1_ready,
                 winner == 0, winner == 1);
      end
      // Transaction model for the coming edge: accept, then result one edge later,
      // then held until the owner's ready is seen.
      if (winner >= 0) begin
        busy = 1; k = winner; last = winner;
        iop = winner == 0 ? req0_aluop : req1_aluop;
        is_ = winner == 0 ? req0_s     : req1_s;
        it  = winner == 0 ? req0_t     : req1_t;
        ish = winner == 0 ? req0_shamt : req1_shamt;
      end else if (busy && !vis) begin
        vis = 1;
        r = alu_ref(iop, is_, it, ish);
        if (k == 0) begin eo0 = r[N-1:0]; ez0 = r[N]; eov0 = r[N+1]; end
        else        begin eo1 = r[N-1:0]; ez1 = r[N]; eov1 = r[N+1]; end
      end else if (vis && ((k == 0) ? resp0_ready : resp1_ready)) begin
        vis = 0; busy = 0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_add();
    test_overflow_req1();
    test_beq_hold();
    test_reset_in_exec();
    test_back_to_back();
    test_round_robin();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
